ascon_enc_arbiter: RTL



---
 rtl/ascon_enc_arbiter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ascon_enc_arbiter.sv
// Round-robin scheduler sharing one Ascon AEAD encryption core among N requesters.
// Ports:
//   clk, rst            : single clock, synchronous active-high reset
//   req                 : per-requester job request (level)
//   key_in/nonce_in/ad_in/pt_in : packed per-requester operands, requester i at [i*W +: W]
//   gnt                 : one-hot grant, one cycle, coincident with core_start
//   core_key/nonce/ad/pt: registered operands held until the next grant
//   core_start          : one-cycle start pulse to the core
//   core_ct/core_tag/core_ready : core results and level done flag
//   resp_valid/ready/id/ct/tag/err : response handshake back to the winner
//   busy                : scheduler not idle
module ascon_enc_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned K   = 128,
  parameter int unsigned L   = 16,
  parameter int unsigned Y   = 16,
  parameter int unsigned IW  = 2,
  parameter int unsigned TMO = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*K-1:0]    key_in,
  input  logic [N*128-1:0]  nonce_in,
  input  logic [N*L-1:0]    ad_in,
  input  logic [N*Y-1:0]    pt_in,
  output logic [N-1:0]      gnt,
  output logic [K-1:0]      core_key,
  output logic [127:0]      core_nonce,
  output logic [L-1:0]      core_ad,
  output logic [Y-1:0]      core_pt,
  output logic              core_start,
  input  logic [Y-1:0]      core_ct,
  input  logic [127:0]      core_tag,
  input  logic              core_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IW-1:0]     resp_id,
  output logic [Y-1:0]      resp_ct,
  output logic [127:0]      resp_tag,
  output logic              resp_err,
  output logic              busy
);

  localparam int unsigned NW  = 128;
  localparam int unsigned WDW = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  last_q, last_d;
  logic [IW-1:0]  cur_id_q, cur_id_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [K-1:0]   core_key_q, core_key_d;
  logic [NW-1:0]  core_nonce_q, core_nonce_d;
  logic [L-1:0]   core_ad_q, core_ad_d;
  logic [Y-1:0]   core_pt_q, core_pt_d;
  logic           core_start_q, core_start_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IW-1:0]  resp_id_q, resp_id_d;
  logic [Y-1:0]   resp_ct_q, resp_ct_d;
  logic [NW-1:0]  resp_tag_q, resp_tag_d;
  logic           resp_err_q, resp_err_d;
  logic           busy_q, busy_d;

  logic           win_found_c;
  logic [IW-1:0]  win_id_c;
  int unsigned    rr_idx_c;
  logic           wd_exp_c;

  // Round-robin pick: first set request searching upward from last+1, wrapping mod N.
  always_comb begin
    win_found_c = 1'b0;
    win_id_c    = '0;
    rr_idx_c    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      rr_idx_c = (32'(last_q) + k) % N;
      if (!win_found_c && req[rr_idx_c[IW-1:0]]) begin
        win_found_c = 1'b1;
        win_id_c    = rr_idx_c[IW-1:0];
      end
    end
  end

  // Watchdog limit reached; wins over a coincident core_ready.
  assign wd_exp_c = (wdog_q == WDW'(TMO - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (win_found_c) state_d = S_START;
      S_START:   state_d = S_WAIT_LO;
      // Wait for the previous job's stale ready to drop before looking for done.
      S_WAIT_LO: begin
        if (wd_exp_c)         state_d = S_RESP;
        else if (!core_ready) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: if (wd_exp_c || core_ready) state_d = S_RESP;
      S_RESP:    if (resp_valid_q && resp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; everything leaves the block through flops.
  always_comb begin
    last_d       = last_q;
    cur_id_d     = cur_id_q;
    wdog_d       = wdog_q;
    core_key_d   = core_key_q;
    core_nonce_d = core_nonce_q;
    core_ad_d    = core_ad_q;
    core_pt_d    = core_pt_q;
    resp_id_d    = resp_id_q;
    resp_ct_d    = resp_ct_q;
    resp_tag_d   = resp_tag_q;
    resp_err_d   = resp_err_q;
    gnt_d        = '0;
    core_start_d = 1'b0;
    resp_valid_d = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (win_found_c) begin
          core_key_d      = key_in[32'(win_id_c) * K +: K];
          core_nonce_d    = nonce_in[32'(win_id_c) * NW +: NW];
          core_ad_d       = ad_in[32'(win_id_c) * L +: L];
          core_pt_d       = pt_in[32'(win_id_c) * Y +: Y];
          gnt_d[win_id_c] = 1'b1;
          core_start_d    = 1'b1;
          cur_id_d        = win_id_c;
          last_d          = win_id_c;
        end
      end
      S_START: wdog_d = '0;
      S_WAIT_LO, S_WAIT_HI: begin
        if (wd_exp_c) begin
          resp_id_d  = cur_id_q;
          resp_ct_d  = '0;
          resp_tag_d = '0;
          resp_err_d = 1'b1;
        end else if ((state_q == S_WAIT_HI) && core_ready) begin
          resp_id_d  = cur_id_q;
          resp_ct_d  = core_ct;
          resp_tag_d = core_tag;
          resp_err_d = 1'b0;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= IW'(N - 1);
      cur_id_q     <= '0;
      wdog_q       <= '0;
      gnt_q        <= '0;
      core_key_q   <= '0;
      core_nonce_q <= '0;
      core_ad_q    <= '0;
      core_pt_q    <= '0;
      core_start_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_ct_q    <= '0;
      resp_tag_q   <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      last_q       <= last_d;
      cur_id_q     <= cur_id_d;
      wdog_q       <= wdog_d;
      gnt_q        <= gnt_d;
      core_key_q   <= core_key_d;
      core_nonce_q <= core_nonce_d;
      core_ad_q    <= core_ad_d;
      core_pt_q    <= core_pt_d;
      core_start_q <= core_start_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_ct_q    <= resp_ct_d;
      resp_tag_q   <= resp_tag_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign core_key   = core_key_q;
  assign core_nonce = core_nonce_q;
  assign core_ad    = core_ad_q;
  assign core_pt    = core_pt_q;
  assign core_start = core_start_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_ct    = resp_ct_q;
  assign resp_tag   = resp_tag_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;

endmodule
